// File: rtl/mcu_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pkg
// Shared definitions for the multicycle MIPS main control unit: opcode
// constants, FSM state encoding, datapath select encodings and the bundled
// control-output struct passed from the output decoder to the top level.
// The alu_op encoding is also consumed by the ALU control unit.
//
// Configuration: define MCU_JUMP_EN to make the J opcode a supported
// instruction; otherwise it is treated as unsupported.
// -----------------------------------------------------------------------------
package mcu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecute,
        StAluWb,
        StBranch,
        StAddiEx,
        StAddiWb,
        StJump
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcBReg   = 2'b00,
        SrcBFour  = 2'b01,
        SrcBImm   = 2'b10,
        SrcBImmSh = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PcSrcAlu    = 2'b00,
        PcSrcAluOut = 2'b01,
        PcSrcJump   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        pc_src_e    pc_src;
        alu_op_e    alu_op;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       bad_op;
    } ctrl_t;

    // True for opcodes the FSM knows how to sequence in this build.
    function automatic logic op_supported(logic [5:0] op);
        logic ok;
        case (op)
            OpRtype, OpLw, OpSw, OpBeq, OpAddi: ok = 1'b1;
`ifdef MCU_JUMP_EN
            OpJ:                                ok = 1'b1;
`endif
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // States whose exit to FETCH retires an instruction.
    function automatic logic is_terminal(state_e st);
        logic term;
        case (st)
            StMemWb, StMemWrite, StAluWb, StBranch, StAddiWb, StJump: term = 1'b1;
            default:                                                  term = 1'b0;
        endcase
        return term;
    endfunction

endpackage

// File: rtl/mcu_output_decoder.sv
// -----------------------------------------------------------------------------
// mcu_output_decoder
// Combinational decode of the current FSM state (plus mem_ready where the
// handshake matters) into every datapath select and enable.
//
// Ports:
//   state_i         current FSM state
//   mem_ready_i     memory handshake; gates IR/PC load in FETCH
//   op_supported_i  opcode in IR is supported (drives bad_op in DECODE)
//   kill_i          forces all outputs to zero (reset held)
//   ctrl_o          bundled control outputs
// -----------------------------------------------------------------------------
module mcu_output_decoder
    import mcu_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   op_supported_i,
    input  logic   kill_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (!kill_i) begin
            unique case (state_i)
                StFetch: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SrcBFour;
                    // IR and PC only advance once the fetch read completes.
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                StDecode: begin
                    ctrl_o.alu_src_b = SrcBImmSh;
                    ctrl_o.bad_op    = ~op_supported_i;
                end
                StMemAdr, StAddiEx: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SrcBImm;
                end
                StMemRead: begin
                    ctrl_o.iord     = 1'b1;
                    ctrl_o.mem_read = 1'b1;
                end
                StMemWb: begin
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                end
                StMemWrite: begin
                    ctrl_o.iord      = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                StExecute: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = AluOpFunct;
                end
                StAluWb: begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                StBranch: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = AluOpSub;
                    ctrl_o.pc_src    = PcSrcAluOut;
                    ctrl_o.branch    = 1'b1;
                end
                StAddiWb: begin
                    ctrl_o.reg_write = 1'b1;
                end
                StJump: begin
                    ctrl_o.pc_src   = PcSrcJump;
                    ctrl_o.pc_write = 1'b1;
                end
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and write-back, stalls on mem_ready in the memory states and
// counts retired instructions.
//
// Configuration: MCU_JUMP_EN enables the J instruction (JUMP state). Without
// it, opcode 000010 raises bad_op and is not counted.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   opcode                instr[31:26] from the instruction register
//   mem_ready             memory completes the current access this cycle
//   mem_read, mem_write   memory requests
//   iord                  memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write    IR load, unconditional PC load
//   branch                PC load qualified by ALU zero
//   pc_src                PC source select
//   alu_op                ALU control class (add / sub / funct)
//   alu_src_a, alu_src_b  ALU operand selects
//   reg_dst, mem_to_reg   register write destination / data selects
//   reg_write             register file write enable
//   bad_op                one-cycle pulse in DECODE on unsupported opcode
//   instr_count           retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             bad_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_ok;
    ctrl_t            ctrl;

    assign op_ok = op_supported(opcode);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
`ifdef MCU_JUMP_EN
                    OpJ:        state_d = StJump;
`endif
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecute:  state_d = StAluWb;
            StAddiEx:   state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Count only completed instructions; the DECODE->FETCH bad_op exit is
    // excluded because DECODE is not a terminal state.
    always_comb begin
        cnt_d = cnt_q;
        if (is_terminal(state_q) && (state_d == StFetch)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mcu_output_decoder u_output_decoder (
        .state_i        (state_q),
        .mem_ready_i    (mem_ready),
        .op_supported_i (op_ok),
        .kill_i         (rst),
        .ctrl_o         (ctrl)
    );

    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign iord        = ctrl.iord;
    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign branch      = ctrl.branch;
    assign pc_src      = ctrl.pc_src;
    assign alu_op      = ctrl.alu_op;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_write   = ctrl.reg_write;
    assign bad_op      = ctrl.bad_op;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_control_unit. A per-instruction model expands each
// issued instruction into its expected cycle-by-cycle control vector and
// retired count; the monitor checks every cycle on the falling edge. A second
// instance with CNT_W=2 shares the stimulus to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] JMP   = 6'b000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'b0;

    logic        mem_read, mem_write, iord, ir_write, pc_write, branch;
    logic [1:0]  pc_src, alu_op, alu_src_b;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, bad_op;
    logic [31:0] instr_count;

    logic        b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_branch;
    logic [1:0]  b_pc_src, b_alu_op, b_alu_src_b;
    logic        b_alu_src_a, b_reg_dst, b_mem_to_reg, b_reg_write, b_bad_op;
    logic [1:0]  b_instr_count;

    multicycle_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .bad_op(bad_op),
        .instr_count(instr_count)
    );

    multicycle_control_unit #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .iord(b_iord),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .branch(b_branch),
        .pc_src(b_pc_src), .alu_op(b_alu_op), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .bad_op(b_bad_op), .instr_count(b_instr_count)
    );

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       bad_op;
    } ctl_t;

    typedef struct {
        ctl_t vec;
        bit   rdy;
    } step_t;

    typedef struct {
        ctl_t        vec;
        int unsigned cnt;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int unsigned retired = 0;
    exp_t        exp_q[$];
    step_t       plan[$];

    function automatic bit supported(logic [5:0] op);
        bit ok;
        ok = (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI);
`ifdef MCU_JUMP_EN
        if (op == JMP) ok = 1'b1;
`endif
        return ok;
    endfunction

    task automatic add(input ctl_t c, input bit r);
        step_t s;
        s.vec = c;
        s.rdy = r;
        plan.push_back(s);
    endtask

    // Expand one instruction into its expected per-cycle control vectors and
    // the mem_ready value to drive in each cycle (random where it is ignored).
    task automatic build(input logic [5:0] op, input int wf, input int wm);
        ctl_t c;
        plan.delete();
        c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
        for (int i = 0; i < wf; i++) add(c, 1'b0);
        c.ir_write = 1; c.pc_write = 1;
        add(c, 1'b1);
        c = '0; c.alu_src_b = 2'b11; c.bad_op = !supported(op);
        add(c, 1'($urandom));
        if (!supported(op)) return;
        if (op == LW || op == SW) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
            add(c, 1'($urandom));
            c = '0; c.iord = 1;
            if (op == LW) c.mem_read = 1; else c.mem_write = 1;
            for (int i = 0; i < wm; i++) add(c, 1'b0);
            add(c, 1'b1);
            if (op == LW) begin
                c = '0; c.mem_to_reg = 1; c.reg_write = 1;
                add(c, 1'($urandom));
            end
        end else if (op == RTYPE) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 2'b10;
            add(c, 1'($urandom));
            c = '0; c.reg_dst = 1; c.reg_write = 1;
            add(c, 1'($urandom));
        end else if (op == BEQ) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1;
            add(c, 1'($urandom));
        end else if (op == ADDI) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
            add(c, 1'($urandom));
            c = '0; c.reg_write = 1;
            add(c, 1'($urandom));
        end else begin
            c = '0; c.pc_src = 2'b10; c.pc_write = 1;
            add(c, 1'($urandom));
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            mem_ready = 1'($urandom);
            opcode = 6'($urandom);
            retired = 0;
            e.vec = '0;
            e.cnt = 0;
            exp_q.push_back(e);
        end
    endtask

    // abort_at >= 0: reset is asserted in that cycle of the instruction.
    task automatic run(input logic [5:0] op, input int wf, input int wm, input int abort_at);
        exp_t e;
        build(op, wf, wm);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(1 + int'($urandom_range(0, 2)));
                return;
            end
            @(posedge clk); #1;
            rst = 1'b0;
            opcode = op;
            mem_ready = plan[i].rdy;
            e.vec = plan[i].vec;
            e.cnt = retired;
            exp_q.push_back(e);
        end
        if (supported(op)) retired++;
    endtask

    // Monitor: one expected entry per cycle, checked on the falling edge.
    initial begin
        exp_t e;
        ctl_t act;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {mem_read, mem_write, iord, ir_write, pc_write, branch, pc_src,
                       alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
                       bad_op};
                total += 3;
                if (act !== e.vec) begin
                    bad++;
                    $display("FAIL ctl cycle=%0d got=%h want=%h", cyc, act, e.vec);
                end
                if (instr_count !== e.cnt) begin
                    bad++;
                    $display("FAIL instr_count cycle=%0d got=%0d want=%0d", cyc,
                             instr_count, e.cnt);
                end
                if (b_instr_count !== 2'(e.cnt % 4)) begin
                    bad++;
                    $display("FAIL instr_count_w2 cycle=%0d got=%0d want=%0d", cyc,
                             b_instr_count, e.cnt % 4);
                end
                cyc++;
            end
        end
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        exp_t       e;
        ctl_t       c;
        ops = '{RTYPE, LW, SW, BEQ, ADDI, JMP, 6'b111111};

        do_reset(3);
        run(LW, 0, 0, -1);
        run(SW, 0, 3, -1);
        run(RTYPE, 0, 0, -1);
        run(BEQ, 0, 0, -1);
        run(6'b111111, 0, 0, -1);
        run(JMP, 0, 0, -1);
        // Reset in the second MEM_READ wait cycle of a stalled load.
        run(LW, 1, 5, 5);
        for (int i = 0; i < 5; i++) run(ADDI, int'($urandom_range(0, 1)), 0, -1);

        for (int n = 0; n < 160; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom);
            run(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        // Trailing fetch stall so the last retirement shows up in the count.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            mem_ready = 1'b0;
            c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
            e.vec = c;
            e.cnt = retired;
            exp_q.push_back(e);
        end

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d entries want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
